// File: rtl/uart_rx_sniffer.sv
// Show-ahead byte FIFO used by the UART sniffer.
// Latency: an entry written on one edge is visible at the read side the next cycle.
// Backpressure: wr_rdy drops when full, unless a pop happens in the same cycle.
module uart_rx_sniffer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             push;
    logic             pop;

    assign rd_vld = (occ != '0);
    assign pop    = rd_vld & rd_rdy;
    // A pop frees the slot the push needs, so push+pop while full is allowed.
    assign wr_rdy = (occ != (AW+1)'(DEPTH)) | pop;
    assign push   = wr_vld & wr_rdy;
    // Head is forced to zero while empty so the output is defined out of reset.
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

// UART receive sniffer: 8N1-style deserialiser with mid-bit sampling and byte FIFO.
// Latency: byte written DATA_BITS*CLK_DIV + 3*CLK_DIV/2 + 3 cycles after the start edge hits io_rxd.
// Backpressure: io_byte_ready stalls the FIFO; a good frame arriving while full is dropped and flagged.
module uart_rx_sniffer #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_rxd,
    input  logic                 io_clear,
    output logic                 io_byte_valid,
    input  logic                 io_byte_ready,
    output logic [DATA_BITS-1:0] io_byte_payload,
    output logic                 io_frame_err,
    output logic                 io_overflow,
    output logic [31:0]          io_rx_count,
    output logic                 io_busy
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 rx_meta;
    logic                 rxs;
    logic [1:0]           sync_fill;
    logic                 armed;
    logic [CW-1:0]        baud_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 sample;
    logic                 baud_load;
    logic [CW-1:0]        load_val;
    logic                 shift_en;
    logic                 good_stop;
    logic                 bad_stop;
    logic                 fifo_wr_rdy;

    assign sample = (baud_cnt == '0);

    // Two-flop synchroniser; sync_fill marks when rxs holds a real line sample
    // rather than the post-reset value, so a line held low across reset never arms.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= io_rxd;
            rxs       <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (armed && !rxs) state_nxt = S_START;
            S_START: if (sample) state_nxt = rxs ? S_IDLE : S_DATA;
            S_DATA:  if (sample && (bit_idx == LAST_BIT)) state_nxt = S_STOP;
            S_STOP:  if (sample) state_nxt = rxs ? S_IDLE : S_BREAK;
            S_BREAK: if (rxs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: baud reloads, shift strobe, stop-bit verdict, busy.
    always_comb begin
        baud_load = 1'b0;
        load_val  = FULL_LOAD;
        shift_en  = 1'b0;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        io_busy   = 1'b1;
        case (state)
            S_IDLE: begin
                io_busy = 1'b0;
                if (armed && !rxs) begin
                    baud_load = 1'b1;
                    load_val  = HALF_LOAD;
                end
            end
            S_START: if (sample && !rxs) baud_load = 1'b1;
            S_DATA: begin
                if (sample) begin
                    shift_en  = 1'b1;
                    baud_load = 1'b1;
                end
            end
            S_STOP: begin
                if (sample) begin
                    good_stop = rxs;
                    bad_stop  = !rxs;
                end
            end
            default: ;
        endcase
    end

    // Baud counter, bit index, shift register and arming flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            armed    <= 1'b0;
        end else begin
            baud_cnt <= baud_load ? load_val : baud_cnt - CW'(1);
            if (shift_en) begin
                bit_idx <= bit_idx + IW'(1);
                shreg   <= {rxs, shreg[DATA_BITS-1:1]};
            end else if (state != S_DATA) begin
                bit_idx <= '0;
            end
            if ((state == S_IDLE) && rxs && sync_fill[1]) armed <= 1'b1;
        end
    end

    // Status: frame-error pulse, sticky overflow and frame counter; clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_frame_err <= 1'b0;
            io_overflow  <= 1'b0;
            io_rx_count  <= '0;
        end else begin
            io_frame_err <= bad_stop;
            if (io_clear) begin
                io_overflow <= 1'b0;
                io_rx_count <= '0;
            end else begin
                if (good_stop) io_rx_count <= io_rx_count + 32'd1;
                if (good_stop && !fifo_wr_rdy) io_overflow <= 1'b1;
            end
        end
    end

    uart_rx_sniffer_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (good_stop),
        .wr_rdy (fifo_wr_rdy),
        .wr_dat (shreg),
        .rd_vld (io_byte_valid),
        .rd_rdy (io_byte_ready),
        .rd_dat (io_byte_payload)
    );
endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Bench for uart_rx_sniffer: frame-level model predicts FIFO contents, counters and flags.
// Latency: model applies each frame's outcome on the edge its stop bit is sampled.
// Backpressure: ready is driven fixed or random; model mirrors drops when the FIFO is full.
module tb_uart_rx_sniffer;
    localparam int CLK_DIV    = 16;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT        = CLK_DIV;
    // Edge (relative to driving the start bit) on which the stop bit is judged:
    // 2 sync flops + 1 detect cycle + half bit + data bits + stop bit centre.
    localparam int EV_LAT     = 3 + CLK_DIV / 2 + (DATA_BITS + 1) * CLK_DIV;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 io_rxd = 1'b1;
    logic                 io_clear = 1'b0;
    logic                 io_byte_ready = 1'b0;
    logic                 io_byte_valid;
    logic [DATA_BITS-1:0] io_byte_payload;
    logic                 io_frame_err;
    logic                 io_overflow;
    logic [31:0]          io_rx_count;
    logic                 io_busy;

    uart_rx_sniffer #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .io_rxd          (io_rxd),
        .io_clear        (io_clear),
        .io_byte_valid   (io_byte_valid),
        .io_byte_ready   (io_byte_ready),
        .io_byte_payload (io_byte_payload),
        .io_frame_err    (io_frame_err),
        .io_overflow     (io_overflow),
        .io_rx_count     (io_rx_count),
        .io_busy         (io_busy)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]          at;
        logic [DATA_BITS-1:0] dat;
        logic                 good;
    } ev_t;

    ev_t                  evq[$];
    logic [DATA_BITS-1:0] mq[$];
    logic [DATA_BITS-1:0] popped[$];
    logic [31:0]          m_count = '0;
    logic                 m_ovf = 1'b0;
    logic                 m_ferr = 1'b0;
    logic                 m_pop;
    logic                 vld_prev = 1'b0;
    int unsigned          rise_cyc = 0;
    int                   vld_cycles = 0;
    int                   ferr_cycles = 0;
    logic                 rand_mode = 1'b0;
    logic                 rdy_fixed = 1'b0;
    logic                 clr_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pop_at(input int i);
        if (i < popped.size()) return 32'(popped[i]);
        return 32'hDEADBEEF;
    endfunction

    // Ready and clear are driven a little after each edge, from one place.
    always @(posedge clk) begin
        #2;
        io_byte_ready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
        io_clear      = clr_req | (rand_mode && ($urandom_range(0, 99) == 0));
    end

    // Compare DUT against the model every cycle, then advance the model by one edge.
    always @(negedge clk) begin
        check("valid", 32'(io_byte_valid), 32'(mq.size() != 0));
        check("payload", 32'(io_byte_payload), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check("rx_count", io_rx_count, m_count);
        check("overflow", 32'(io_overflow), 32'(m_ovf));
        check("frame_err", 32'(io_frame_err), 32'(m_ferr));
        if (io_byte_valid && !vld_prev) rise_cyc = cyc;
        vld_prev = io_byte_valid;
        if (io_byte_valid) vld_cycles++;
        if (io_frame_err) ferr_cycles++;
        if (io_byte_valid && io_byte_ready && !reset) popped.push_back(io_byte_payload);
        if (reset) begin
            mq.delete();
            evq.delete();
            m_count = '0;
            m_ovf   = 1'b0;
            m_ferr  = 1'b0;
        end else begin
            m_pop  = (mq.size() != 0) && io_byte_ready;
            m_ferr = 1'b0;
            if (m_pop) void'(mq.pop_front());
            if ((evq.size() != 0) && (evq[0].at == cyc + 1)) begin
                if (evq[0].good) begin
                    m_count = m_count + 32'd1;
                    if (mq.size() < FIFO_DEPTH) mq.push_back(evq[0].dat);
                    else m_ovf = 1'b1;
                end else begin
                    m_ferr = 1'b1;
                end
                void'(evq.pop_front());
            end
            if (io_clear) begin
                m_count = '0;
                m_ovf   = 1'b0;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        io_rxd = v;
        wait_cycles(n);
    endtask

    task automatic pulse_clear();
        clr_req = 1'b1;
        wait_cycles(1);
        clr_req = 1'b0;
        wait_cycles(1);
    endtask

    // Stop bit held for BIT+stop_extra cycles at the given level.
    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic good, input int stop_extra);
        ev_t e;
        e.at   = cyc + EV_LAT;
        e.dat  = d;
        e.good = good;
        evq.push_back(e);
        hold(1'b0, BIT);
        for (int i = 0; i < DATA_BITS; i++) hold(d[i], BIT);
        hold(good, BIT + stop_extra);
    endtask

    initial begin
        int unsigned p0;
        wait_cycles(3);
        check("rst valid", 32'(io_byte_valid), 32'd0);
        check("rst payload", 32'(io_byte_payload), 32'd0);
        check("rst frame_err", 32'(io_frame_err), 32'd0);
        check("rst overflow", 32'(io_overflow), 32'd0);
        check("rst count", io_rx_count, 32'd0);
        check("rst busy", 32'(io_busy), 32'd0);
        reset = 1'b0;
        hold(1'b1, 8);

        // Single byte with ready high.
        rdy_fixed = 1'b1;
        wait_cycles(2);
        popped.delete();
        vld_cycles = 0;
        p0 = cyc;
        send_frame(8'h55, 1'b1, 0);
        hold(1'b1, 10);
        check("t1 latency", rise_cyc - p0, 32'd155);
        check("t1 valid cycles", 32'(vld_cycles), 32'd1);
        check("t1 byte", pop_at(0), 32'h55);
        check("t1 count", io_rx_count, 32'd1);
        check("t1 overflow", 32'(io_overflow), 32'd0);

        // Two bytes held, then drained.
        pulse_clear();
        rdy_fixed = 1'b0;
        popped.delete();
        send_frame(8'hA5, 1'b1, 0);
        send_frame(8'h3C, 1'b1, 0);
        hold(1'b1, 10);
        check("t2 held valid", 32'(io_byte_valid), 32'd1);
        check("t2 held head", 32'(io_byte_payload), 32'hA5);
        rdy_fixed = 1'b1;
        wait_cycles(5);
        check("t2 byte0", pop_at(0), 32'hA5);
        check("t2 byte1", pop_at(1), 32'h3C);
        check("t2 npop", 32'(popped.size()), 32'd2);
        check("t2 valid after", 32'(io_byte_valid), 32'd0);
        check("t2 count", io_rx_count, 32'd2);

        // Overflow with five bytes into four entries.
        pulse_clear();
        rdy_fixed = 1'b0;
        wait_cycles(2);
        popped.delete();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
        hold(1'b1, 10);
        check("t3 overflow", 32'(io_overflow), 32'd1);
        check("t3 count", io_rx_count, 32'd5);
        pulse_clear();
        check("t3 cleared overflow", 32'(io_overflow), 32'd0);
        check("t3 cleared count", io_rx_count, 32'd0);
        rdy_fixed = 1'b1;
        wait_cycles(8);
        for (int i = 0; i < 4; i++) check("t3 drain", pop_at(i), 32'(i + 1));
        check("t3 npop", 32'(popped.size()), 32'd4);

        // Bad stop bit followed by a long break, then a good byte.
        pulse_clear();
        popped.delete();
        ferr_cycles = 0;
        send_frame(8'h00, 1'b0, 40);
        check("t4 busy in break", 32'(io_busy), 32'd1);
        hold(1'b1, 4);
        check("t4 busy after break", 32'(io_busy), 32'd0);
        hold(1'b1, 12);
        check("t4 frame_err cycles", 32'(ferr_cycles), 32'd1);
        check("t4 count", io_rx_count, 32'd0);
        check("t4 npop", 32'(popped.size()), 32'd0);
        send_frame(8'h7E, 1'b1, 0);
        hold(1'b1, 10);
        check("t4 byte", pop_at(0), 32'h7E);
        check("t4 count after", io_rx_count, 32'd1);

        // Short low glitch on an idle line.
        pulse_clear();
        vld_cycles = 0;
        ferr_cycles = 0;
        hold(1'b0, 4);
        check("t5 busy glitch", 32'(io_busy), 32'd1);
        hold(1'b1, CLK_DIV / 2 + 3 - 4);
        check("t5 busy cleared", 32'(io_busy), 32'd0);
        hold(1'b1, 16);
        check("t5 valid cycles", 32'(vld_cycles), 32'd0);
        check("t5 frame_err", 32'(ferr_cycles), 32'd0);
        check("t5 count", io_rx_count, 32'd0);

        // Reset mid-frame with the line held low through release.
        pulse_clear();
        popped.delete();
        hold(1'b0, BIT);
        hold(1'b1, BIT);
        hold(1'b0, BIT);
        hold(1'b0, BIT);
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        hold(1'b0, 20);
        check("t6 busy low line", 32'(io_busy), 32'd0);
        check("t6 valid low line", 32'(io_byte_valid), 32'd0);
        hold(1'b1, 16);
        send_frame(8'h81, 1'b1, 0);
        hold(1'b1, 10);
        check("t6 npop", 32'(popped.size()), 32'd1);
        check("t6 byte", pop_at(0), 32'h81);
        check("t6 count", io_rx_count, 32'd1);

        // Randomised traffic: bytes, bad stops, glitches, ready and clear.
        rand_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                send_frame(8'($urandom), 1'b0, int'($urandom_range(0, 30)));
                hold(1'b1, 4 + int'($urandom_range(0, 10)));
            end else if (kind == 1) begin
                hold(1'b0, int'($urandom_range(1, 5)));
                hold(1'b1, 16);
            end else begin
                send_frame(8'($urandom), 1'b1, int'($urandom_range(0, 6)));
            end
        end
        hold(1'b1, 20);
        rand_mode = 1'b0;
        rdy_fixed = 1'b1;
        wait_cycles(10);
        check("end drained", 32'(io_byte_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        fails++;
        $display("FAIL watchdog: simulation did not end, expected finish within time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_rx_sniffer.md
Name: uart_rx_sniffer

Overview:
- Serial receiver that consumes the SoC UART transmit line (io_uart_txd of the SoC top) and turns it into a byte stream for the simulation bench and console logger.
- Fixed 8N1-style framing. Mid-bit sampling from a programmable clock divider.
- Small show-ahead FIFO with valid/ready output.
- Status flags: frame errors, overflow, and a 32-bit received-frame counter.

Parameters:
- CLK_DIV, 16: clock cycles per UART bit; even, >= 4.
- DATA_BITS, 8: data bits per frame, LSB first; range 5..8.
- FIFO_DEPTH, 4: byte FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_rxd  in  1  serial line, idle high; asynchronous to clk
- io_clear  in  1  synchronous clear of io_overflow and io_rx_count
- io_byte_valid  out  1  FIFO not empty
- io_byte_ready  in  1  consumer accepts head byte
- io_byte_payload  out  DATA_BITS  FIFO head byte, zero-extended at the top
- io_frame_err  out  1  one-cycle pulse on a bad stop bit
- io_overflow  out  1  sticky; a good frame was dropped because the FIFO was full
- io_rx_count  out  32  good frames received, dropped ones included; wraps modulo 2^32
- io_busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - Sync flops = 1, FSM = IDLE, armed = 0, FIFO empty.
  - io_byte_valid = 0, io_byte_payload = 0, io_frame_err = 0, io_overflow = 0, io_rx_count = 0, io_busy = 0.
- Input sync: io_rxd passes through two flops; rxs denotes the second flop. All decisions use rxs. This adds 2 cycles of latency.
- Armed flag: set when IDLE sees rxs = 1. A start is accepted only while armed, so a line held low across reset release is never taken as a start.
- Baud counter: loaded with a value N, decrements each cycle, and samples on the cycle it equals 0, i.e. N+1 cycles after the load.
- FSM states and transitions:
  - IDLE: armed and rxs = 0 -> load CLK_DIV/2-1 -> START.
  - START: on sample, rxs = 1 -> false start -> IDLE (stays armed, no flags). rxs = 0 -> load CLK_DIV-1, bit index = 0 -> DATA.
  - DATA: on each sample, shift rxs in at the MSB (shift right). After DATA_BITS samples -> load CLK_DIV-1 -> STOP.
  - STOP, sample rxs = 1:
    - Frame is good; io_rx_count increments.
    - Byte is pushed to the FIFO, or dropped with io_overflow set if the FIFO is full and not popping that cycle.
    - -> IDLE. A new start may be detected the following cycle.
  - STOP, sample rxs = 0: io_frame_err pulses exactly 1 cycle; byte discarded, no count; -> BREAK.
  - BREAK: wait for rxs = 1 -> IDLE (armed).
- Timing: the stop-bit sample occurs DATA_BITS*CLK_DIV + CLK_DIV/2 + CLK_DIV cycles after the IDLE cycle that detected the start. The FIFO write happens on that sample cycle; io_byte_valid rises the next cycle.
- FIFO:
  - Show-ahead: io_byte_payload is the head entry whenever io_byte_valid = 1.
  - Pop when io_byte_valid & io_byte_ready.
  - Push and pop in the same cycle while full: both happen, occupancy unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only (valid was 0).
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Order is preserved.
- io_clear:
  - Zeros io_overflow and io_rx_count next cycle.
  - When coincident with an increment or overflow set, clear wins.
  - Does not touch the FIFO or the FSM.
- Reset mid-frame: partial byte discarded, FSM -> IDLE with armed = 0, FIFO flushed.
- io_busy = 1 in START, DATA, STOP and BREAK.

Test Plan:
- CLK_DIV=16; send 0x55 with ready=1:
  - io_byte_valid pulses 1 cycle with payload 0x55.
  - io_rx_count=1; io_frame_err and io_overflow stay 0.
- Send 0xA5 then 0x3C back-to-back with ready=0:
  - valid stays 1 with head 0xA5.
  - Raise ready: 0xA5 then 0x3C on consecutive cycles, then valid=0; count=2.
- Send 5 bytes 0x01..0x05 with ready=0 (DEPTH 4):
  - FIFO holds 0x01..0x04, 0x05 dropped.
  - io_overflow=1, count=5.
  - Pulse io_clear: overflow=0, count=0, FIFO still drains 0x01..0x04.
- Frame 0x00 with stop bit low, line held low 40 cycles, then high:
  - io_frame_err high exactly 1 cycle; no push; count unchanged; io_busy=1 until line returns high.
  - A following 0x7E is received correctly.
- Low glitch of 4 cycles on idle line: false start, no output, no flags; io_busy returns to 0 within CLK_DIV/2+3 cycles.
- Assert reset after 3 data bits of 0x81, keep io_rxd low through reset release for 20 cycles, then idle high and send 0x81:
  - No byte and no start while low after release.
  - Exactly one 0x81 delivered; count=1.
